fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 43 ++++
 rtl/fetch_stage.sv | 80 ++++++++
 tb/tb_fetch_stage.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, redirect request from execute,
// and the decoupled instruction stream handed to decode.
interface fetch_stage_if;
    // Decode handshake: an entry transfers in any cycle where out_valid and
    // out_ready are both high; while out_valid=1 and out_ready=0 the out_*
    // fields hold, and out_valid never depends on out_ready in the same cycle.
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        misalign_err;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output out_pc_plus4,
        output misalign_err
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  out_pc_plus4,
        input  misalign_err
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: sequential PC generation feeding a 2-entry {pc, instr}
// FIFO toward decode, with redirect flush and misaligned-target flagging.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master io_bus
);

    logic [31:0] r_fpc;
    logic [31:0] r_pc_q    [2];
    logic [31:0] r_instr_q [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;
    logic        r_misalign;

    logic        w_valid;
    logic        w_pop;
    logic        w_fetch_en;
    logic        w_push;
    logic [31:0] w_redirect_target;
    logic [31:0] w_out_pc;

    assign w_valid           = (r_count != 2'd0);
    assign w_pop             = w_valid & io_bus.out_ready;
    assign w_fetch_en        = (r_count < 2'd2) | w_pop;
    assign w_push            = ~io_bus.redirect_valid & w_fetch_en;
    assign w_redirect_target = {io_bus.redirect_pc[31:2], 2'b00};

    // Control state; redirect outranks push and pop, so a pop accepted in the
    // redirect cycle is simply dropped with the rest of the FIFO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fpc      <= {RESET_PC[31:2], 2'b00};
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_misalign <= 1'b0;
        end else if (io_bus.redirect_valid) begin
            r_fpc      <= w_redirect_target;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_misalign <= |io_bus.redirect_pc[1:0];
        end else begin
            r_misalign <= 1'b0;
            if (w_push) begin
                r_fpc    <= r_fpc + 32'd4;
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: count gates visibility of every slot.
    always_ff @(posedge clk) begin
        if (rst && !io_bus.redirect_valid && w_push) begin
            r_pc_q[r_wr_ptr]    <= r_fpc;
            r_instr_q[r_wr_ptr] <= io_bus.imem_rdata;
        end
    end

    assign w_out_pc            = w_valid ? r_pc_q[r_rd_ptr] : 32'h0;
    assign io_bus.imem_addr    = r_fpc;
    assign io_bus.out_valid    = w_valid;
    assign io_bus.out_pc       = w_out_pc;
    assign io_bus.out_instr    = w_valid ? r_instr_q[r_rd_ptr] : 32'h0;
    assign io_bus.out_pc_plus4 = w_out_pc + 32'd4;
    assign io_bus.misalign_err = r_misalign;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed streaming, backpressure,
// redirect, wrap and reset scenarios, then randomized ready/redirect traffic.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] XOR_KEY  = 32'hA5A5_0000;

    logic clk;
    logic rst;
    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    // Instruction memory model: word is a keyed function of its address.
    assign bus.imem_rdata = bus.imem_addr ^ XOR_KEY;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          errors;
    int          pops_seen;
    int          pops_base;
    logic        hold_pending;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected delivery order after a reset or redirect: consecutive words.
    task automatic seed(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 80; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    // Mid-cycle observation: scoreboard every transfer, and check that a
    // stalled head stays put across the following edge.
    task automatic sample();
        logic [31:0] e;
        if (rst) begin
            if (hold_pending) begin
                check_eq("hold_valid", {31'b0, bus.out_valid}, 32'd1);
                check_eq("hold_pc", bus.out_pc, hold_pc);
                check_eq("hold_instr", bus.out_instr, hold_instr);
            end
            if (bus.out_valid && bus.out_ready) begin
                check_eq("q_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("out_pc", bus.out_pc, e);
                    check_eq("out_instr", bus.out_instr, e ^ XOR_KEY);
                    check_eq("out_pc_plus4", bus.out_pc_plus4, e + 32'd4);
                end
                pops_seen++;
            end
            hold_pending = bus.out_valid && !bus.out_ready && !bus.redirect_valid;
            hold_pc      = bus.out_pc;
            hold_instr   = bus.out_instr;
        end else begin
            hold_pending = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        check_eq("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        check_eq("rst_addr", bus.imem_addr, RESET_PC);
        check_eq("rst_misalign", {31'b0, bus.misalign_err}, 32'd0);
        rst = 1'b1;
        seed(RESET_PC);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        logic [31:0] aligned;
        aligned = {target[31:2], 2'b00};
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        tick();
        bus.redirect_valid = 1'b0;
        seed(aligned);
        check_eq("redir_addr", bus.imem_addr, aligned);
        check_eq("redir_flush", {31'b0, bus.out_valid}, 32'd0);
        check_eq("redir_misalign", {31'b0, bus.misalign_err}, {31'b0, target[1:0] != 2'b00});
        tick();
        check_eq("redir_valid2", {31'b0, bus.out_valid}, 32'd1);
        check_eq("redir_pc2", bus.out_pc, aligned);
        check_eq("redir_misalign2", {31'b0, bus.misalign_err}, 32'd0);
    endtask

    initial begin
        checks             = 0;
        errors             = 0;
        pops_seen          = 0;
        hold_pending       = 1'b0;
        hold_pc            = '0;
        hold_instr         = '0;
        rst                = 1'b0;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        @(posedge clk);
        #1;

        // Streaming with a consumer that is always ready.
        do_reset();
        bus.out_ready = 1'b1;
        check_eq("first_cycle_valid", {31'b0, bus.out_valid}, 32'd0);
        pops_base = pops_seen;
        tick();
        check_eq("second_cycle_valid", {31'b0, bus.out_valid}, 32'd1);
        check_eq("second_cycle_pc", bus.out_pc, RESET_PC);
        for (int i = 0; i < 11; i++) tick();
        check_eq("stream_rate", 32'(pops_seen - pops_base), 32'd11);

        // Backpressure from reset, then drain.
        bus.out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        check_eq("bp_addr", bus.imem_addr, 32'd8);
        check_eq("bp_pc", bus.out_pc, 32'd0);
        pops_base = pops_seen;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_eq("bp_drain", 32'(pops_seen - pops_base), 32'd4);

        // Redirect while the FIFO holds pcs 8 and 12.
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        bus.out_ready = 1'b0;
        tick();
        check_eq("pre_redir_pc", bus.out_pc, 32'd8);
        do_redirect(32'h0000_0100);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // Misaligned target, then address wrap.
        do_redirect(32'h0000_0206);
        for (int i = 0; i < 3; i++) tick();
        do_redirect(32'hFFFF_FFF8);
        for (int i = 0; i < 4; i++) tick();

        // Back-to-back redirects: only the second target may appear.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0300;
        tick();
        bus.redirect_pc    = 32'h0000_0400;
        tick();
        bus.redirect_valid = 1'b0;
        seed(32'h0000_0400);
        check_eq("b2b_addr", bus.imem_addr, 32'h0000_0400);
        for (int i = 0; i < 4; i++) tick();

        // Reset mid-stream with a full FIFO.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        seed(RESET_PC);
        check_eq("midrst_valid", {31'b0, bus.out_valid}, 32'd0);
        tick();
        check_eq("midrst_pc", bus.out_pc, RESET_PC);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // Random ready and occasional random redirects.
        for (int i = 0; i < 150; i++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) do_redirect($urandom);
            else tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
